// File: rtl/audio_pkg.sv
// Shared types and constants for the audio front end and the sample recorder.
package audio_pkg;

  localparam int SAMPLE_W            = 8;
  localparam int DEFAULT_MAX_SAMPLES = 18000;
  localparam int COUNT_W             = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RECORDING,
    FULL
  } rec_state_t;

  // Clamp a centred PDM density to the signed 8-bit sample range.
  function automatic sample_t sat_sample(input int value);
    if (value > 127) begin
      return sample_t'(127);
    end else if (value < -128) begin
      return sample_t'(-128);
    end else begin
      return sample_t'(value);
    end
  endfunction

endpackage

// File: rtl/audio_front_end_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the output level
// only follows the button once it has held a new level long enough.
module audio_front_end_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic level_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn_in};
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level_out = level_reg;

endmodule

// File: rtl/audio_front_end.sv
// PDM clock generation, PDM-to-PCM decimation and the sample-aligned record
// gate that feeds the recorder.
module audio_front_end
  import audio_pkg::*;
#(
  parameter int PDM_DIV         = 32,
  parameter int DECIM           = 256,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_SAMPLES     = DEFAULT_MAX_SAMPLES
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                pdm_data_in,
  input  logic                record_btn_in,
  output logic                pdm_clk_out,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid_out,
  output logic                record_out,
  output logic                rec_full_out,
  output logic [COUNT_W-1:0]  rec_count_out
);

  localparam int DIV_W = $clog2(PDM_DIV);
  localparam int BIT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PDM_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DECIM - 1);
  localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_SAMPLES);

  logic [1:0]       pdm_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             pdm_clk_reg;
  logic             capture;
  logic [8:0]       ones_reg, ones_sum;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [8:0]       final_reg;
  logic             final_valid_reg;
  sample_t          audio_reg;
  logic             valid_reg;

  logic               btn_level;
  rec_state_t         state_reg, state_next;
  logic               record_reg, record_next;
  logic               full_reg, full_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  assign div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
  assign capture      = (div_cnt_reg == DIV_LAST);
  assign ones_sum     = ones_reg + 9'(pdm_sync_reg[1]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pdm_sync_reg    <= 2'b00;
      div_cnt_reg     <= '0;
      pdm_clk_reg     <= 1'b1;
      ones_reg        <= '0;
      bit_cnt_reg     <= '0;
      final_reg       <= '0;
      final_valid_reg <= 1'b0;
      audio_reg       <= '0;
      valid_reg       <= 1'b0;
    end else begin
      pdm_sync_reg    <= {pdm_sync_reg[0], pdm_data_in};
      div_cnt_reg     <= div_cnt_next;
      // Registered from the next count so the pin tracks the live div_cnt.
      pdm_clk_reg     <= (int'(div_cnt_next) < PDM_DIV / 2);
      final_valid_reg <= 1'b0;
      if (capture) begin
        if (bit_cnt_reg == BIT_LAST) begin
          final_reg       <= ones_sum;
          final_valid_reg <= 1'b1;
          ones_reg        <= '0;
          bit_cnt_reg     <= '0;
        end else begin
          ones_reg    <= ones_sum;
          bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
        end
      end
      valid_reg <= final_valid_reg;
      if (final_valid_reg) begin
        audio_reg <= sat_sample(int'(final_reg) - DECIM / 2);
      end
    end
  end

  audio_front_end_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .btn_in   (record_btn_in),
    .level_out(btn_level)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= IDLE;
      record_reg <= 1'b0;
      full_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      record_reg <= record_next;
      full_reg   <= full_next;
      count_reg  <= count_next;
    end
  end

  // Gate and count only move on a strobe cycle, so the recorder never sees
  // the gate change underneath a valid sample.
  always_comb begin
    state_next  = state_reg;
    record_next = record_reg;
    full_next   = full_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (btn_level) begin
          state_next = ARMED;
          count_next = '0;
          full_next  = 1'b0;
        end
      end
      ARMED: begin
        if (!btn_level) begin
          state_next = IDLE;
        end else if (valid_reg) begin
          state_next  = RECORDING;
          record_next = 1'b1;
        end
      end
      RECORDING: begin
        if (valid_reg && record_reg && (count_reg < MAX_CNT)) begin
          count_next = count_reg + COUNT_W'(1);
          if (count_next == MAX_CNT) begin
            state_next  = FULL;
            record_next = 1'b0;
            full_next   = 1'b1;
          end else if (!btn_level) begin
            state_next  = IDLE;
            record_next = 1'b0;
          end
        end
      end
      FULL: begin
        if (!btn_level) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        record_next = 1'b0;
      end
    endcase
  end

  assign pdm_clk_out     = pdm_clk_reg;
  assign audio_out       = audio_reg;
  assign audio_valid_out = valid_reg;
  assign record_out      = record_reg;
  assign rec_full_out    = full_reg;
  assign rec_count_out   = count_reg;

endmodule

// File: tb/tb_audio_front_end.sv
// Bench for audio_front_end: a small-parameter instance for timing and the
// record gate, and a default-parameter instance for saturation.
module tb_audio_front_end;

  typedef struct {
    int period;
    int high;
    int expected;
  } pat_vec_t;

  logic        clk;
  logic        rst_n, rst_n_d;
  logic        pdm_s, pdm_d, btn_s, btn_d;
  logic        pdm_clk_s, valid_s, record_s, full_s;
  logic        pdm_clk_d, valid_d, record_d, full_d;
  logic [7:0]  audio_s, audio_d;
  logic [15:0] count_s, count_d;

  int checks = 0;
  int failures = 0;
  int per_s = 1, high_s = 1, per_d = 1, high_d = 1;
  int tcnt = 0;
  int exp_q_s[$];
  int exp_q_d[$];
  bit done_d = 0;

  audio_front_end #(
    .PDM_DIV(4), .DECIM(8), .DEBOUNCE_CYCLES(16), .MAX_SAMPLES(5)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pdm_data_in(pdm_s), .record_btn_in(btn_s),
    .pdm_clk_out(pdm_clk_s), .audio_out(audio_s), .audio_valid_out(valid_s),
    .record_out(record_s), .rec_full_out(full_s), .rec_count_out(count_s)
  );

  audio_front_end #(
    .PDM_DIV(32), .DECIM(256), .DEBOUNCE_CYCLES(16), .MAX_SAMPLES(18000)
  ) dut_def (
    .clk_in(clk), .rst_n_in(rst_n_d), .pdm_data_in(pdm_d), .record_btn_in(btn_d),
    .pdm_clk_out(pdm_clk_d), .audio_out(audio_d), .audio_valid_out(valid_d),
    .record_out(record_d), .rec_full_out(full_d), .rec_count_out(count_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic PDM patterns; high/period are multiples of the capture spacing,
  // so the ones count per sample does not depend on phase.
  initial begin
    pdm_s = 1'b1;
    pdm_d = 1'b1;
    forever begin
      @(negedge clk);
      tcnt++;
      pdm_s = ((tcnt % per_s) < high_s);
      pdm_d = ((tcnt % per_d) < high_d);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end else begin
      $display("  ok %s = %0d", name, actual);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end else begin
      $display("  ok %s = %0d", name, actual);
    end
  endtask

  // Advances at least one edge, then waits (bounded) for the next strobe.
  task automatic wait_strobe(input int which, input int limit, output int cycles);
    logic v;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      v = (which == 0) ? valid_s : valid_d;
    end while (!v && cycles < limit);
    if (!v) begin
      checks++;
      failures++;
      $display("FAIL strobe_timeout dut=%0d waited=%0d required=strobe", which, cycles);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid_s && exp_q_s.size() > 0) begin
        check("small_sample", int'($signed(audio_s)), exp_q_s.pop_front());
      end
      if (valid_d && exp_q_d.size() > 0) begin
        check("default_sample", int'($signed(audio_d)), exp_q_d.pop_front());
      end
    end
  end

  // Default-parameter instance: saturation and mid-scale.
  initial begin
    pat_vec_t vd[3];
    int c;
    vd[0] = '{period: 1,  high: 1,  expected: 127};
    vd[1] = '{period: 1,  high: 0,  expected: -128};
    vd[2] = '{period: 64, high: 32, expected: 0};
    btn_d   = 1'b0;
    rst_n_d = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      per_d  = vd[i].period;
      high_d = vd[i].high;
      wait_strobe(1, 9000, c);
      @(negedge clk);
      exp_q_d.push_back(vd[i].expected);
      wait_strobe(1, 9000, c);
      @(negedge clk);
      check("default_sb_drained", exp_q_d.size(), 0);
    end
    done_d = 1;
  end

  initial begin
    pat_vec_t vs[6];
    int pclk_exp[8];
    int c, first, n;
    bit rec_seen;
    vs[0] = '{period: 1,  high: 0,  expected: -4};
    vs[1] = '{period: 8,  high: 4,  expected: 0};
    vs[2] = '{period: 16, high: 4,  expected: -2};
    vs[3] = '{period: 32, high: 4,  expected: -3};
    vs[4] = '{period: 16, high: 12, expected: 2};
    vs[5] = '{period: 1,  high: 1,  expected: 4};
    pclk_exp = '{1, 0, 0, 1, 1, 0, 0, 1};

    btn_s = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pdm_clk", int'(pdm_clk_s), 1);
    check("rst_audio", int'(audio_s), 0);
    check("rst_valid", int'(valid_s), 0);
    check("rst_record", int'(record_s), 0);
    check("rst_full", int'(full_s), 0);
    check("rst_count", int'(count_s), 0);

    rst_n = 1'b1;
    first = -1;
    for (int e = 1; e <= 60 && first < 0; e++) begin
      @(posedge clk);
      #1;
      if (e <= 8) check($sformatf("pdm_clk_edge%0d", e), int'(pdm_clk_s), pclk_exp[e-1]);
      if (valid_s) first = e;
    end
    check_range("first_strobe_latency", first, 33, 35);
    check("first_sample", int'($signed(audio_s)), 4);
    wait_strobe(0, 200, c);
    check("strobe_spacing", c, 32);
    @(posedge clk);
    #1;
    check("strobe_one_cycle", int'(valid_s), 0);
    check("audio_holds", int'($signed(audio_s)), 4);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      per_s  = vs[i].period;
      high_s = vs[i].high;
      wait_strobe(0, 200, c);
      @(negedge clk);
      exp_q_s.push_back(vs[i].expected);
      wait_strobe(0, 200, c);
      @(negedge clk);
      check("small_sb_drained", exp_q_s.size(), 0);
    end

    // Short glitch must not reach the debounced level.
    wait_strobe(0, 200, c);
    @(negedge clk);
    btn_s = 1'b1;
    repeat (10) @(negedge clk);
    btn_s = 1'b0;
    rec_seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (record_s) rec_seen = 1;
    end
    check("pulse_no_record", int'(rec_seen), 0);
    check("pulse_count", int'(count_s), 0);

    // Held press: arm, open gate after one strobe, fill to the limit.
    wait_strobe(0, 200, c);
    @(negedge clk);
    btn_s = 1'b1;
    wait_strobe(0, 200, c);
    check("gate_closed_at_arm_strobe", int'(record_s), 0);
    @(posedge clk);
    #1;
    check("gate_opens", int'(record_s), 1);
    check("count_at_open", int'(count_s), 0);
    for (int k = 1; k <= 5; k++) begin
      wait_strobe(0, 200, c);
      check($sformatf("gate_at_strobe%0d", k), int'(record_s), 1);
      @(posedge clk);
      #1;
      check($sformatf("count_after%0d", k), int'(count_s), k);
      check($sformatf("record_after%0d", k), int'(record_s), (k < 5) ? 1 : 0);
      check($sformatf("full_after%0d", k), int'(full_s), (k < 5) ? 0 : 1);
    end
    n = 0;
    repeat (2) begin
      wait_strobe(0, 200, c);
      if (record_s) n++;
    end
    check("full_no_restart", n, 0);
    check("full_held", int'(full_s), 1);
    check("full_count_held", int'(count_s), 5);
    @(negedge clk);
    btn_s = 1'b0;
    repeat (30) @(negedge clk);
    check("released_full_held", int'(full_s), 1);
    check("released_count_held", int'(count_s), 5);

    // Fresh press clears status; release after two samples closes the gate.
    wait_strobe(0, 200, c);
    @(negedge clk);
    btn_s = 1'b1;
    repeat (24) @(negedge clk);
    check("rearm_count_cleared", int'(count_s), 0);
    check("rearm_full_cleared", int'(full_s), 0);
    check("rearm_record", int'(record_s), 0);
    wait_strobe(0, 200, c);
    @(posedge clk);
    #1;
    check("second_gate_opens", int'(record_s), 1);
    wait_strobe(0, 200, c);
    wait_strobe(0, 200, c);
    @(posedge clk);
    #1;
    check("count_before_release", int'(count_s), 2);
    @(negedge clk);
    btn_s = 1'b0;
    wait_strobe(0, 200, c);
    @(posedge clk);
    #1;
    check("release_count", int'(count_s), 3);
    check("release_record", int'(record_s), 0);
    check("release_full", int'(full_s), 0);
    wait_strobe(0, 200, c);
    wait_strobe(0, 200, c);
    check("idle_count_held", int'(count_s), 3);
    check("idle_record", int'(record_s), 0);

    // Asynchronous reset in the middle of a recording.
    wait_strobe(0, 200, c);
    @(negedge clk);
    btn_s = 1'b1;
    wait_strobe(0, 200, c);
    wait_strobe(0, 200, c);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_record", int'(record_s), 0);
    check("async_rst_count", int'(count_s), 0);
    check("async_rst_audio", int'(audio_s), 0);
    check("async_rst_full", int'(full_s), 0);
    check("async_rst_valid", int'(valid_s), 0);
    check("async_rst_pdm_clk", int'(pdm_clk_s), 1);
    btn_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int e = 1; e <= 60 && first < 0; e++) begin
      @(posedge clk);
      #1;
      if (valid_s) first = e;
    end
    check_range("post_rst_strobe_latency", first, 33, 35);
    check("post_rst_sample", int'($signed(audio_s)), 4);

    n = 0;
    while (!done_d && n < 60000) begin
      @(posedge clk);
      n++;
    end
    check("default_run_done", int'(done_d), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
